// File: rtl/vesa_timing_monitor.sv
// vesa_timing_monitor
//   Downstream checker for the VESA timing generator. Measures clocks per
//   line, de-high clocks per active line, lines per frame and de-bearing
//   lines per frame. A lock FSM compares each completed frame with the
//   expected mode.
//
//   State table:
//     SEARCH | no matching frame seen yet, or the last frame mismatched
//     TRACK  | good_cnt consecutive matching frames, not yet LOCK_FRAMES
//     LOCKED | timing matches the expected mode
//
// Ports:
//   clk, rst_n              pixel clock, async active-low reset
//   hsync, vsync, de        timing generator outputs under test
//   meas_h_total            clocks per line (last complete line)
//   meas_h_active           de-high clocks of the last active line
//   meas_v_total            lines in the last complete frame
//   meas_v_active           de-bearing lines in the last complete frame
//   meas_valid              1-clk pulse when meas_* update
//   h_active_inconsistent   last frame had differing de lengths
//   locked                  timing matches the expected mode
//   lock_lost               1-clk pulse on LOCKED -> SEARCH
//   no_signal               hsync absent for TIMEOUT clocks
module vesa_timing_monitor #(
    parameter int EXP_H_TOTAL     = 1600,
    parameter int EXP_H_ACTIVE    = 1280,
    parameter int EXP_V_TOTAL     = 748,
    parameter int EXP_V_ACTIVE    = 720,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 3,
    parameter int TIMEOUT         = 4096,
    parameter int HW              = 12,
    parameter int VW              = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [HW-1:0] meas_h_total,
    output logic [HW-1:0] meas_h_active,
    output logic [VW-1:0] meas_v_total,
    output logic [VW-1:0] meas_v_active,
    output logic          meas_valid,
    output logic          h_active_inconsistent,
    output logic          locked,
    output logic          lock_lost,
    output logic          no_signal
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic            POL     = (SYNC_ACTIVE_LOW != 0);
    localparam logic [HW-1:0]   H_MAX   = '1;
    localparam logic [VW-1:0]   V_MAX   = '1;
    localparam logic [HW-1:0]   EXP_HT  = HW'(EXP_H_TOTAL);
    localparam logic [HW-1:0]   EXP_HA  = HW'(EXP_H_ACTIVE);
    localparam logic [VW-1:0]   EXP_VT  = VW'(EXP_V_TOTAL);
    localparam logic [VW-1:0]   EXP_VA  = VW'(EXP_V_ACTIVE);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]      LOCK_N  = 4'(LOCK_FRAMES);

    // Syncs are normalised to 1 = active on the way into the first register.
    logic hs_r, hs_rr, vs_r, vs_rr, de_r, de_rr;
    logic hs_edge, vs_edge, de_rise, de_fall;

    logic [HW-1:0] h_cnt, h_line, de_cnt, h_act, h_ref;
    logic [VW-1:0] v_cnt, va_cnt;
    logic          h_armed, v_armed, ref_set, incons;
    logic [TW-1:0] to_cnt;
    logic          ns_fire;

    logic [HW-1:0] h_line_nx, h_act_nx;
    logic [VW-1:0] v_cnt_nx, va_cnt_nx;
    logic          incons_nx;

    logic [HW-1:0] snap_ht, snap_ha;
    logic [VW-1:0] snap_vt, snap_va;
    logic          snap_inc, snap_vld, snap_match;
    logic          st2_vld, st2_match;

    state_t        state;
    logic [3:0]    good_cnt;

    assign hs_edge = hs_r & ~hs_rr;
    assign vs_edge = vs_r & ~vs_rr;
    assign de_rise = de_r & ~de_rr;
    assign de_fall = ~de_r & de_rr;
    assign ns_fire = ~no_signal & ~hs_edge & (to_cnt == TO_LAST);

    // Next values include same-clock events so that a frame end coinciding
    // with an hs edge or de fall still accounts for it in the ending frame.
    always_comb begin
        h_line_nx = h_line;
        if (hs_edge && h_armed)
            h_line_nx = (h_cnt == H_MAX) ? H_MAX : h_cnt + 1'b1;
        h_act_nx  = de_fall ? de_cnt : h_act;
        incons_nx = incons | (de_fall & ref_set & (de_cnt != h_ref));
        v_cnt_nx  = (hs_edge && v_cnt != V_MAX) ? v_cnt + 1'b1 : v_cnt;
        va_cnt_nx = (de_rise && va_cnt != V_MAX) ? va_cnt + 1'b1 : va_cnt;
    end

    // All-ones on any measurement means a counter saturated: never a match.
    assign snap_match = (snap_ht == EXP_HT) && (snap_ha == EXP_HA) &&
                        (snap_vt == EXP_VT) && (snap_va == EXP_VA) && !snap_inc &&
                        (snap_ht != H_MAX) && (snap_ha != H_MAX) &&
                        (snap_vt != V_MAX) && (snap_va != V_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hs_r, hs_rr, vs_r, vs_rr, de_r, de_rr} <= '0;
            h_cnt   <= '0;  h_line <= '0;  de_cnt <= '0;  h_act <= '0;  h_ref <= '0;
            v_cnt   <= '0;  va_cnt <= '0;
            h_armed <= 1'b0; v_armed <= 1'b0; ref_set <= 1'b0; incons <= 1'b0;
            to_cnt  <= '0;  no_signal <= 1'b0;
            snap_ht <= '0;  snap_ha <= '0;  snap_vt <= '0;  snap_va <= '0;
            snap_inc <= 1'b0; snap_vld <= 1'b0;
            st2_vld <= 1'b0; st2_match <= 1'b0;
            meas_h_total <= '0; meas_h_active <= '0;
            meas_v_total <= '0; meas_v_active <= '0;
            meas_valid <= 1'b0; h_active_inconsistent <= 1'b0;
        end else begin
            hs_r  <= hsync ^ POL;
            vs_r  <= vsync ^ POL;
            de_r  <= de;
            hs_rr <= hs_r;
            vs_rr <= vs_r;
            de_rr <= de_r;

            if (hs_edge)            h_cnt <= '0;
            else if (h_cnt != H_MAX) h_cnt <= h_cnt + 1'b1;
            if (hs_edge) h_armed <= 1'b1;
            h_line <= h_line_nx;

            if (de_fall)                     de_cnt <= '0;
            else if (de_r && de_cnt != H_MAX) de_cnt <= de_cnt + 1'b1;
            h_act <= h_act_nx;

            if (vs_edge) begin
                snap_ht  <= h_line_nx;
                snap_ha  <= h_act_nx;
                snap_vt  <= v_cnt_nx;
                snap_va  <= va_cnt_nx;
                snap_inc <= incons_nx;
                // First frame after arming is partial; meas_* freeze during no_signal.
                snap_vld <= v_armed & ~no_signal;
                v_armed  <= 1'b1;
                v_cnt    <= '0;
                va_cnt   <= '0;
                incons   <= 1'b0;
                ref_set  <= 1'b0;
            end else begin
                snap_vld <= 1'b0;
                v_cnt    <= v_cnt_nx;
                va_cnt   <= va_cnt_nx;
                incons   <= incons_nx;
                if (de_fall && !ref_set) begin
                    h_ref   <= de_cnt;
                    ref_set <= 1'b1;
                end
            end

            st2_vld   <= snap_vld;
            st2_match <= snap_match;

            meas_valid <= st2_vld;
            if (st2_vld) begin
                meas_h_total          <= snap_ht;
                meas_h_active         <= snap_ha;
                meas_v_total          <= snap_vt;
                meas_v_active         <= snap_va;
                h_active_inconsistent <= snap_inc;
            end

            if (hs_edge) begin
                to_cnt    <= '0;
                no_signal <= 1'b0;
            end else if (ns_fire) begin
                no_signal <= 1'b1;
                h_armed   <= 1'b0;
                v_armed   <= 1'b0;
            end else if (!no_signal) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Frame decisions use the same stage that loads meas_*, so locked and
    // lock_lost change on the clock that meas_valid rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            good_cnt  <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            if (ns_fire) begin
                if (state == LOCKED) lock_lost <= 1'b1;
                state    <= SEARCH;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (st2_vld) begin
                unique case (state)
                    SEARCH: if (st2_match) begin
                        good_cnt <= 4'd1;
                        if (LOCK_N <= 4'd1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= TRACK;
                        end
                    end
                    TRACK: if (st2_match) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= LOCK_N) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        state    <= SEARCH;
                        good_cnt <= '0;
                    end
                    LOCKED: if (!st2_match) begin
                        state     <= SEARCH;
                        good_cnt  <= '0;
                        locked    <= 1'b0;
                        lock_lost <= 1'b1;
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule
